// File: rtl/bcd_sub_serial.sv
// bcd_sub_serial: digit-serial BCD subtractor, diff = a - b - bin, one digit per clock, LSD first.
module bcd_sub_serial #(
    parameter int DIGITS = 100
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] diff,
    output logic                bout,
    output logic                invalid
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS);
    typedef enum logic {IDLE, RUN} state_t;
    state_t          state, state_nx;
    logic [W-1:0]    a_r, b_r, work;
    logic            br, last, inv_in;
    logic [IW-1:0]   idx;
    logic [4:0]      t;
    logic [3:0]      dig;
    assign last = idx == IW'(DIGITS - 1);
    assign t    = {1'b0, a_r[3:0]} - {1'b0, b_r[3:0]} - {4'b0, br};
    // t spans -16..15, so bit 4 is the sign and doubles as the next borrow
    assign dig  = t[4] ? t[3:0] + 4'd10 : t[3:0];
    assign busy = state == RUN;
    always_comb begin
        inv_in = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            inv_in = inv_in | (a[4*i +: 4] > 4'd9) | (b[4*i +: 4] > 4'd9);
    end
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = start ? RUN : IDLE;
        else
            state_nx = last ? IDLE : RUN;
    end
    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) state <= IDLE;
        else          state <= state_nx;
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            a_r     <= '0;
            b_r     <= '0;
            work    <= '0;
            br      <= 1'b0;
            idx     <= '0;
            diff    <= '0;
            bout    <= 1'b0;
            invalid <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_r     <= a;
                    b_r     <= b;
                    br      <= bin;
                    idx     <= '0;
                    invalid <= inv_in;
                end
            end else begin
                a_r  <= a_r >> 4;
                b_r  <= b_r >> 4;
                work <= {dig, work[W-1:4]};
                br   <= t[4];
                idx  <= idx + 1'b1;
                if (last) begin
                    diff <= {dig, work[W-1:4]};
                    bout <= t[4];
                    done <= 1'b1;
                    idx  <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_sub_serial.sv
// tb_bcd_sub_serial: checks 4- and 100-digit instances against integer and BCD-adder models.
module tb_bcd_sub_serial;
    logic clk = 1'b0, aresetn = 1'b0;
    logic s4 = 1'b0, bi4 = 1'b0, s1 = 1'b0, bi1 = 1'b0;
    logic [15:0]  a4 = '0, b4 = '0, diff4;
    logic [399:0] a1 = '0, b1 = '0, diff1;
    logic busy4, done4, bout4, inv4, busy1, done1, bout1, inv1;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    bcd_sub_serial #(.DIGITS(4)) u4 (.clk(clk), .aresetn(aresetn), .start(s4), .a(a4), .b(b4),
        .bin(bi4), .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .invalid(inv4));
    bcd_sub_serial #(.DIGITS(100)) u1 (.clk(clk), .aresetn(aresetn), .start(s1), .a(a1), .b(b1),
        .bin(bi1), .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .invalid(inv1));

    task automatic chk(input string tag, input logic [399:0] got, input logic [399:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [400:0] bcd_add(input logic [399:0] x, input logic [399:0] y,
                                              input logic cin, input int n);
        logic [399:0] s = '0;
        int c = cin;
        for (int i = 0; i < n; i++) begin
            int d = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + c;
            c = d > 9 ? 1 : 0;
            s[4*i +: 4] = 4'(d - 10 * c);
        end
        return {c[0], s};
    endfunction

    function automatic logic [399:0] rand_bcd(input int n);
        logic [399:0] r = '0;
        for (int i = 0; i < n; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    function automatic int bcd2int(input logic [15:0] x);
        return x[15:12] * 1000 + x[11:8] * 100 + x[7:4] * 10 + x[3:0];
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic wait4(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!done4 && lat < 50);
        if (!done4) chk("timeout4", 0, 1);
    endtask

    task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic bi,
                       output logic [15:0] d, output logic bo, output logic inv0, output int lat);
        @(posedge clk);
        #1 a4 = a; b4 = b; bi4 = bi; s4 = 1'b1;
        @(posedge clk);
        #1 s4 = 1'b0; inv0 = inv4;
        a4 = 16'($urandom); b4 = 16'($urandom); bi4 = 1'($urandom);
        wait4(lat);
        d = diff4; bo = bout4;
    endtask

    task automatic op100(input logic [399:0] a, input logic [399:0] b, input logic bi,
                         output logic [399:0] d, output logic bo, output int lat);
        @(posedge clk);
        #1 a1 = a; b1 = b; bi1 = bi; s1 = 1'b1;
        @(posedge clk);
        #1 s1 = 1'b0; a1 = rand_bcd(100); b1 = rand_bcd(100); bi1 = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!done1 && lat < 300);
        if (!done1) chk("timeout100", 0, 1);
        d = diff1; bo = bout1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]  d;
        logic [399:0] dd, ra, rb;
        logic [400:0] sum;
        logic         bo, inv0, rbi;
        int           lat, e, cnt;
        repeat (2) @(negedge clk);
        chk("rst_state4", {busy4, done4, diff4, bout4, inv4}, 0);
        chk("rst_state100", {busy1, done1, diff1, bout1, inv1}, 0);
        @(posedge clk);
        #1 aresetn = 1'b1;

        op4(16'h1000, 16'h0001, 1'b0, d, bo, inv0, lat);
        chk("t1_lat", lat, 4);
        chk("t1_diff", d, 16'h0999);
        chk("t1_bout", bo, 0);
        chk("t1_inv", inv4, 0);

        op4(16'h0000, 16'h0001, 1'b0, d, bo, inv0, lat);
        chk("t2_diff", d, 16'h9999);
        chk("t2_bout", bo, 1);
        sum = bcd_add({384'b0, d}, 400'h0001, 1'b0, 4);
        chk("t2_addback", {sum[400], sum[15:0]}, {1'b1, 16'h0000});

        // back-to-back with an ignored start pulse mid-operation
        @(posedge clk);
        #1 a4 = 16'h4321; b4 = 16'h1234; bi4 = 1'b1; s4 = 1'b1;
        @(posedge clk);
        #1 s4 = 1'b0; a4 = 16'h9999;
        @(posedge clk);
        #1 s4 = 1'b1; b4 = 16'h0000;
        @(posedge clk);
        #1 s4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t3_done", done4, 1);
        chk("t3_busy", busy4, 0);
        chk("t3_diff", diff4, 16'h3086);
        chk("t3_bout", bout4, 0);
        a4 = 16'h0500; b4 = 16'h0500; bi4 = 1'b0; s4 = 1'b1;
        @(posedge clk);
        #1 s4 = 1'b0;
        chk("t3b_busy", busy4, 1);
        chk("t3b_held", diff4, 16'h3086);
        wait4(lat);
        chk("t3b_lat", lat, 4);
        chk("t3b_diff", diff4, 16'h0000);
        chk("t3b_bout", bout4, 0);

        op4(16'h00A0, 16'h0000, 1'b0, d, bo, inv0, lat);
        chk("t4_inv_start", inv0, 1);
        chk("t4_diff", d, 16'h00A0);
        chk("t4_bout", bo, 0);
        chk("t4_inv", inv4, 1);

        // async reset mid-run
        @(posedge clk);
        #1 a4 = 16'h5555; b4 = 16'h1111; bi4 = 1'b0; s4 = 1'b1;
        @(posedge clk);
        #1 s4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b0;
        #1 chk("t5_rst_outs", {busy4, done4, diff4, bout4, inv4}, 0);
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done4) cnt++;
        end
        chk("t5_no_done", cnt, 0);
        op4(16'h5555, 16'h1111, 1'b0, d, bo, inv0, lat);
        chk("t5_after_lat", lat, 4);
        chk("t5_after_diff", d, 16'h4444);

        repeat (40) begin
            ra = rand_bcd(4); rb = rand_bcd(4); rbi = 1'($urandom);
            op4(ra[15:0], rb[15:0], rbi, d, bo, inv0, lat);
            e = bcd2int(ra[15:0]) - bcd2int(rb[15:0]) - int'(rbi);
            chk("r4_bout", bo, e < 0);
            chk("r4_diff", d, int2bcd(e < 0 ? e + 10000 : e));
        end

        repeat (150) begin
            ra = rand_bcd(100); rb = rand_bcd(100); rbi = 1'($urandom);
            op100(ra, rb, rbi, dd, bo, lat);
            sum = bcd_add(dd, rb, rbi, 100);
            chk("r100_lat", lat, 100);
            chk("r100_sum", sum[399:0], ra);
            chk("r100_cout", bo, sum[400]);
            chk("r100_inv", inv1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
